// File: rtl/vote_input_debounce_if.sv
// Board-side bundle for the voter input conditioning stage:
// raw switch levels in, clean levels plus status out.
interface vote_input_debounce_if;
    logic x_raw;
    logic y_raw;
    logic z_raw;
    logic x;
    logic y;
    logic z;
    logic changed;
    logic vote_valid;

    // Board / stimulus side: drives raw levels, observes results.
    modport master (
        output x_raw,
        output y_raw,
        output z_raw,
        input  x,
        input  y,
        input  z,
        input  changed,
        input  vote_valid
    );

    // Conditioning stage side.
    modport slave (
        input  x_raw,
        input  y_raw,
        input  z_raw,
        output x,
        output y,
        output z,
        output changed,
        output vote_valid
    );
endinterface

// File: rtl/vote_input_debounce.sv
// Three-channel synchroniser + debouncer feeding the majority voter,
// with a shared change strobe and a startup hold-off flag.
module vote_input_debounce #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input logic                    clk,
    input logic                    rst,
    vote_input_debounce_if.slave   bus
);

    localparam int NCH = 3;

    // Final count value before the output is allowed to follow.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   deb_q;
    logic [NCH-1:0]   deb_d;
    logic [NCH-1:0]   fire;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             chg_q;
    logic             chg_d;

    logic [CNT_W-1:0] st_cnt_q;
    logic [CNT_W-1:0] st_cnt_d;
    logic [1:0]       arm_q;
    logic [1:0]       arm_d;
    logic             valid_q;
    logic             valid_d;

    assign raw = {bus.z_raw, bus.y_raw, bus.x_raw};

    // Two-flop synchroniser per channel; the only consumer of raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Per-channel stability count: any return to the held level
    // clears it, so bounce always restarts the run from zero.
    always_comb begin
        deb_d = deb_q;
        fire  = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
                fire[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        chg_d = |fire;
    end

    // Debounced levels, counters and the merged change strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= '0;
            chg_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            chg_q <= chg_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Startup hold-off: count to LAST, then two arm stages so the
    // flag rises on the same edge a steady input would first appear.
    always_comb begin
        st_cnt_d = st_cnt_q;
        arm_d    = arm_q;
        valid_d  = valid_q;
        if (!valid_q) begin
            if (st_cnt_q != LAST) begin
                st_cnt_d = st_cnt_q + 1'b1;
            end
            arm_d[0] = arm_q[0] | (st_cnt_q == LAST);
            arm_d[1] = arm_q[0];
            valid_d  = arm_q[1];
        end
    end

    // Startup counter and sticky valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_cnt_q <= '0;
            arm_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            st_cnt_q <= st_cnt_d;
            arm_q    <= arm_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.x          = deb_q[0];
    assign bus.y          = deb_q[1];
    assign bus.z          = deb_q[2];
    assign bus.changed    = chg_q;
    assign bus.vote_valid = valid_q;

endmodule

// File: tb/tb_vote_input_debounce.sv
// Randomised and directed bench for vote_input_debounce,
// checked against a sample-history reference model.
module tb_vote_input_debounce;

    localparam int S = 4;
    localparam int W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vote_input_debounce_if bus ();

    vote_input_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the level seen by the debouncer at an edge is the raw
    // sample taken two edges earlier; an output follows after S
    // consecutive differing observations.
    bit hist [3][$];
    bit m_out [3];
    int m_run [3];
    bit m_chg;
    int m_edges;

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            hist[c] = {1'b0, 1'b0};
            m_out[c] = 1'b0;
            m_run[c] = 0;
        end
        m_chg = 1'b0;
        m_edges = 0;
    endfunction

    function automatic void model_step();
        bit [2:0] r;
        bit v;
        if (rst) begin
            model_reset();
            return;
        end
        r = {bus.z_raw, bus.y_raw, bus.x_raw};
        m_chg = 1'b0;
        for (int c = 0; c < 3; c++) begin
            v = hist[c][0];
            hist[c].push_back(r[c]);
            void'(hist[c].pop_front());
            if (v != m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == S) begin
                    m_out[c] = v;
                    m_run[c] = 0;
                    m_chg = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        if (m_edges < 1000) m_edges++;
    endfunction

    function automatic logic [4:0] model_vec();
        return {(m_edges >= S + 2), m_chg,
                m_out[2], m_out[1], m_out[0]};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus.vote_valid, bus.changed,
                bus.z, bus.y, bus.x};
    endfunction

    function automatic logic maj(input logic a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_raw(input logic [2:0] v);
        bus.x_raw = v[0];
        bus.y_raw = v[1];
        bus.z_raw = v[2];
    endtask

    task automatic settle(input logic [2:0] v);
        set_raw(v);
        repeat (8) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL settle: got %b exp %b",
                         dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] e;
        set_raw(3'b111);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b exp %b",
                         i, dut_vec(), 5'b0);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = (i >= 6) ? {1'b1, (i == 6), 3'b111} : 5'b0;
            checks++;
            if (dut_vec() !== e) begin
                errors++;
                $display("FAIL reset_release[%0d]: got %b exp %b",
                         i, dut_vec(), e);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_model[%0d]: got %b exp %b",
                         i, dut_vec(), model_vec());
            end
        end
        settle(3'b000);
    endtask

    task automatic test_clean_step();
        logic [4:0] e;
        set_raw(3'b010);
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = {1'b1, (i == 6), 1'b0, (i >= 6), 1'b0};
            checks++;
            if (dut_vec() !== e) begin
                errors++;
                $display("FAIL clean_step[%0d]: got %b exp %b",
                         i, dut_vec(), e);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 12; i++) begin
            bus.z_raw = (i < 8) ? ((i % 2) == 0) : 1'b0;
            tick();
            checks++;
            if ({bus.z, bus.changed} !== 2'b00) begin
                errors++;
                $display("FAIL bounce[%0d]: got z=%b chg=%b exp 0 0",
                         i, bus.z, bus.changed);
            end
        end
        bus.z_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if ({bus.z, bus.changed} !== {i == 6, i == 6}) begin
                errors++;
                $display("FAIL bounce_hold[%0d]: got %b%b exp %b%b",
                         i, bus.z, bus.changed, i == 6, i == 6);
            end
        end
        settle(3'b000);
    endtask

    task automatic test_simultaneous();
        logic [4:0] e;
        set_raw(3'b111);
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = {1'b1, (i == 6), (i >= 6) ? 3'b111 : 3'b000};
            checks++;
            if (dut_vec() !== e) begin
                errors++;
                $display("FAIL simultaneous[%0d]: got %b exp %b",
                         i, dut_vec(), e);
            end
        end
        settle(3'b000);
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        bus.x_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got %b exp %b",
                     dut_vec(), 5'b0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = {(i >= 6), (i == 6), 2'b00, (i >= 6)};
            checks++;
            if (dut_vec() !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got %b exp %b",
                         i, dut_vec(), e);
            end
        end
    endtask

    task automatic test_voter();
        logic [2:0] pat [5];
        logic       want [5];
        logic       prev;
        logic       e;
        pat  = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b111};
        want = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        prev = maj(m_out[0], m_out[1], m_out[2]);
        for (int p = 0; p < 5; p++) begin
            set_raw({pat[p][0], pat[p][1], pat[p][2]});
            for (int k = 1; k <= 10; k++) begin
                tick();
                e = (k >= 6) ? want[p] : prev;
                checks++;
                if (maj(bus.x, bus.y, bus.z) !== e) begin
                    errors++;
                    $display("FAIL voter[%0d/%0d]: got %b exp %b",
                             p, k, maj(bus.x, bus.y, bus.z), e);
                end
            end
            prev = want[p];
        end
    endtask

    task automatic test_back_to_back();
        settle(3'b000);
        bus.x_raw = 1'b1;
        tick();
        bus.y_raw = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            tick();
            checks++;
            if (bus.changed !== (i == 6 || i == 7)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b exp %b",
                         i, bus.changed, (i == 6 || i == 7));
            end
        end
        settle(3'b000);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                set_raw(3'($urandom_range(0, 7)));
            end
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %b exp %b",
                         n, dut_vec(), model_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        set_raw(3'b000);
        model_reset();
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_voter();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
